rx_decap_ctrl: RTL and testbench
================================

Name: rx_decap_ctrl

Overview:
Controller that sequences the ethernet_decapsulation engine for one GMII receive port. It gates the engine enable so that it only engages at frame boundaries, and detects frame start and end from the engine idle flag. It classifies each frame's outcome, keeps saturating statistics, and recovers the engine after aborts and hangs. Each per-frame result is presented to the host over a valid/ready status port.

Parameters:
MAX_FRAME_CYCLES, 12500, cycles allowed from frame start to engine idle before declaring a timeout
RST_CYCLES, 4, number of cycles dec_rst is held high during recovery
IFG_CYCLES, 12, consecutive gmii_dv-low cycles required before the engine is enabled
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  receive clock, shared with the engine
rst_n  in  1  asynchronous, active-low reset
cfg_enable  in  1  host enable for reception
gmii_dv  in  1  GMII data valid, monitored only
gmii_er  in  1  GMII error, monitored only
dec_en  out  1  drives the engine's gmii_en
dec_rst  out  1  drives the engine's synchronous, active-high rst
dec_idle  in  1  engine data_out_en; 1 = engine in IDLE
dec_crc_ok  in  1  engine ncrc_err; 1 = FCS matched
dec_adr_err  in  1  engine address error
dec_len_err  in  1  engine length error
st_valid  out  1  frame status available
st_ready  in  1  host accepts the status
st_code  out  3  0 OK, 1 CRC, 2 ADDR, 3 LEN, 4 ABORT, 5 TIMEOUT
st_ovf  out  1  sticky: a status was lost because the holding register was full
stat_clr  in  1  synchronous clear of all counters and st_ovf
cnt_ok, cnt_crc, cnt_adr, cnt_abort, cnt_tmo  out  CNT_W each  saturating counters

Behaviour:
- Reset (rst_n=0, asynchronous): state=DISABLED, dec_en=0, dec_rst=1, st_valid=0, st_code=0, st_ovf=0, all counters=0, timers=0.
- State DISABLED: dec_en=0, dec_rst=1.
  - If cfg_enable=1, go to WAIT_IFG.
- State WAIT_IFG: dec_en=0, dec_rst=0.
  - An ifg counter increments while gmii_dv=0 and clears when gmii_dv=1.
  - When the counter reaches IFG_CYCLES, go to IDLE.
  - Purpose: enabling mid-frame never engages the engine on a partial frame.
- State IDLE: dec_en=1.
  - If dec_idle=0 (engine has left IDLE), go to RECV and clear the frame timer.
  - If cfg_enable=0, go to DISABLED.
- State RECV: dec_en=1; the frame timer increments every cycle. Exits, highest priority first:
  - Timer reaches MAX_FRAME_CYCLES-1: code=TIMEOUT, go to RECOVER.
  - gmii_er=1 while gmii_dv=1: code=ABORT, go to RECOVER.
  - dec_idle=1: go to DONE.
  - cfg_enable=0 alone does not exit RECV; the frame completes first, then the FSM goes DISABLED from DONE.
- State DONE (exactly one cycle):
  - Classify by priority ADDR > LEN > CRC > OK, where CRC applies when dec_crc_ok=0.
  - Post the status and go to IDLE, or to DISABLED if cfg_enable=0.
- State RECOVER: dec_en=0, dec_rst=1 for RST_CYCLES cycles, then go to WAIT_IFG.
  - Posting the status and incrementing the counter happen on entry.
- Status posting (from DONE or on RECOVER entry):
  - If st_valid=0 or (st_valid & st_ready) in the same cycle: load st_code, st_valid=1 next cycle.
  - Otherwise: drop the new status, set st_ovf=1; the counter still increments.
  - Posting has one-cycle latency from the DONE/RECOVER-entry edge.
- Status handshake: st_valid & st_ready clears st_valid on the next edge. st_code holds stable while st_valid=1.
- Counter mapping: OK→cnt_ok, CRC→cnt_crc, ADDR→cnt_adr, ABORT→cnt_abort, TIMEOUT→cnt_tmo. LEN has no counter.
- Counters saturate at 2^CNT_W-1 with no wrap.
- stat_clr versus increment in the same cycle: clear wins and the result is 0. stat_clr does not affect the FSM or st_valid.
- dec_rst is registered and glitch-free. dec_en is registered and changes only on state transitions.

Decomposition:
- Shared package rx_ctrl_pkg holds:
  - the state enum (DISABLED, WAIT_IFG, IDLE, RECV, DONE, RECOVER);
  - the st_code enum of 3-bit constants;
  - the counter width default.
- One sub-module, sat_counter (inputs inc, clr; parameter W), instantiated five times.
- The FSM, timers and status register stay in rx_decap_ctrl.

Test Plan:
- Reset, then cfg_enable=1 with gmii_dv low for 12 cycles → dec_en=1 on cycle 13. Then hold dec_idle=0 for 80 cycles, assert dec_idle=1 with crc_ok=1 → st_valid=1, st_code=0, cnt_ok=1.
- cfg_enable rises while gmii_dv=1 → dec_en stays 0 until dv has been low for 12 consecutive cycles. A 5-cycle dv-low gap then dv high restarts the count.
- In RECV, gmii_er=1 with dv=1 → dec_en=0, dec_rst=1 for exactly 4 cycles, st_code=4, cnt_abort=1, then WAIT_IFG.
- Hold dec_idle=0 for 12500 cycles → TIMEOUT posted (code 5), cnt_tmo=1, engine reset.
- Hold st_ready=0 across two completed frames (ADDR, then OK) → st_code stays 2, st_ovf=1, cnt_adr=1, cnt_ok=1. Then stat_clr → counters=0, st_ovf=0, st_valid still 1.
- Force cnt_ok to 0xFFFF and complete an OK frame → stays 0xFFFF. stat_clr and an increment in the same cycle → 0.

Source files
------------

// File: rtl/rx_decap_ctrl_pkg.sv
// Shared types for the GMII receive decapsulation controller: FSM states,
// per-frame status codes and the default statistics counter width.
package rx_ctrl_pkg;

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    WAIT_IFG = 3'd1,
    IDLE     = 3'd2,
    RECV     = 3'd3,
    DONE     = 3'd4,
    RECOVER  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_CRC     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_LEN     = 3'd3,
    ST_ABORT   = 3'd4,
    ST_TIMEOUT = 3'd5
  } st_code_t;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/rx_decap_ctrl_if.sv
// Per-frame status port between the receive controller and the host.
// Handshake: st_code is held stable while st_valid=1; a transfer happens on
// a clock edge where st_valid & st_ready, after which st_valid drops unless a
// new status is loaded in that same edge.
interface rx_decap_ctrl_if;
  import rx_ctrl_pkg::*;

  logic     st_valid;
  logic     st_ready;
  st_code_t st_code;
  logic     st_ovf;

  modport master (
    output st_valid,
    output st_code,
    output st_ovf,
    input  st_ready
  );

  modport slave (
    input  st_valid,
    input  st_code,
    input  st_ovf,
    output st_ready
  );

endinterface

// File: rtl/rx_decap_ctrl_sat_counter.sv
// Saturating event counter; a synchronous clear takes precedence over an
// increment in the same cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rx_decap_ctrl.sv
// Sequences the ethernet decapsulation engine for one GMII receive port:
// frame-boundary gating, outcome classification, statistics and recovery.
module rx_decap_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int MAX_FRAME_CYCLES = 12500,
  parameter int RST_CYCLES       = 4,
  parameter int IFG_CYCLES       = 12,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_enable,
  input  logic               gmii_dv,
  input  logic               gmii_er,
  output logic               dec_en,
  output logic               dec_rst,
  input  logic               dec_idle,
  input  logic               dec_crc_ok,
  input  logic               dec_adr_err,
  input  logic               dec_len_err,
  rx_decap_ctrl_if.master    st,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   cnt_ok,
  output logic [CNT_W-1:0]   cnt_crc,
  output logic [CNT_W-1:0]   cnt_adr,
  output logic [CNT_W-1:0]   cnt_abort,
  output logic [CNT_W-1:0]   cnt_tmo,
  output state_t             dbg_state
);

  localparam int TMR_W = (MAX_FRAME_CYCLES > 1) ? $clog2(MAX_FRAME_CYCLES) : 1;
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAX_FRAME_CYCLES - 1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  state_t           state, state_nxt;
  logic [IFG_W-1:0] ifg_cnt, ifg_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [RST_W-1:0] rst_cnt, rst_nxt;
  st_code_t         code_q, code_nxt;
  logic             post;
  st_code_t         post_code;

  logic             dec_en_q, dec_rst_q;
  logic             st_valid_q, st_ovf_q;
  st_code_t         st_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DISABLED;
      ifg_cnt <= '0;
      tmr     <= '0;
      rst_cnt <= '0;
      code_q  <= ST_OK;
    end else begin
      state   <= state_nxt;
      ifg_cnt <= ifg_nxt;
      tmr     <= tmr_nxt;
      rst_cnt <= rst_nxt;
      code_q  <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ifg_nxt   = ifg_cnt;
    tmr_nxt   = tmr;
    rst_nxt   = rst_cnt;
    code_nxt  = code_q;
    post      = 1'b0;
    post_code = code_q;

    case (state)
      DISABLED: begin
        ifg_nxt = '0;
        if (cfg_enable) state_nxt = WAIT_IFG;
      end

      // Only a full inter-frame gap proves we are between frames.
      WAIT_IFG: begin
        if (!cfg_enable) begin
          state_nxt = DISABLED;
          ifg_nxt   = '0;
        end else if (gmii_dv) begin
          ifg_nxt = '0;
        end else if (ifg_cnt == IFG_LAST) begin
          state_nxt = IDLE;
          ifg_nxt   = '0;
        end else begin
          ifg_nxt = ifg_cnt + 1'b1;
        end
      end

      IDLE: begin
        if (!dec_idle) begin
          state_nxt = RECV;
          tmr_nxt   = '0;
        end else if (!cfg_enable) begin
          state_nxt = DISABLED;
        end
      end

      RECV: begin
        tmr_nxt = tmr + 1'b1;
        if (tmr == TMR_LAST) begin
          state_nxt = RECOVER;
          code_nxt  = ST_TIMEOUT;
          rst_nxt   = '0;
        end else if (gmii_er && gmii_dv) begin
          state_nxt = RECOVER;
          code_nxt  = ST_ABORT;
          rst_nxt   = '0;
        end else if (dec_idle) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        post = 1'b1;
        if (dec_adr_err)      post_code = ST_ADDR;
        else if (dec_len_err) post_code = ST_LEN;
        else if (!dec_crc_ok) post_code = ST_CRC;
        else                  post_code = ST_OK;
        state_nxt = cfg_enable ? IDLE : DISABLED;
      end

      // The outcome is posted in the first recovery cycle; the engine is
      // then held in reset for the full recovery window.
      RECOVER: begin
        post = (rst_cnt == '0);
        if (rst_cnt == RST_LAST) begin
          state_nxt = WAIT_IFG;
          rst_nxt   = '0;
          ifg_nxt   = '0;
        end else begin
          rst_nxt = rst_cnt + 1'b1;
        end
      end

      default: state_nxt = DISABLED;
    endcase
  end

  // Engine controls are decoded from the next state so they are registered
  // and only move on state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_en_q  <= 1'b0;
      dec_rst_q <= 1'b1;
    end else begin
      dec_en_q  <= (state_nxt == IDLE) || (state_nxt == RECV) || (state_nxt == DONE);
      dec_rst_q <= (state_nxt == DISABLED) || (state_nxt == RECOVER);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_q <= 1'b0;
      st_code_q  <= ST_OK;
    end else if (post && (!st_valid_q || st.st_ready)) begin
      st_valid_q <= 1'b1;
      st_code_q  <= post_code;
    end else if (st_valid_q && st.st_ready) begin
      st_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_ovf_q <= 1'b0;
    end else if (stat_clr) begin
      st_ovf_q <= 1'b0;
    end else if (post && st_valid_q && !st.st_ready) begin
      st_ovf_q <= 1'b1;
    end
  end

  logic inc_ok, inc_crc, inc_adr, inc_abort, inc_tmo;

  assign inc_ok    = post && (post_code == ST_OK);
  assign inc_crc   = post && (post_code == ST_CRC);
  assign inc_adr   = post && (post_code == ST_ADDR);
  assign inc_abort = post && (post_code == ST_ABORT);
  assign inc_tmo   = post && (post_code == ST_TIMEOUT);

  sat_counter #(.W(CNT_W)) u_cnt_ok (
    .clk(clk), .rst_n(rst_n), .inc(inc_ok), .clr(stat_clr), .cnt(cnt_ok)
  );
  sat_counter #(.W(CNT_W)) u_cnt_crc (
    .clk(clk), .rst_n(rst_n), .inc(inc_crc), .clr(stat_clr), .cnt(cnt_crc)
  );
  sat_counter #(.W(CNT_W)) u_cnt_adr (
    .clk(clk), .rst_n(rst_n), .inc(inc_adr), .clr(stat_clr), .cnt(cnt_adr)
  );
  sat_counter #(.W(CNT_W)) u_cnt_abort (
    .clk(clk), .rst_n(rst_n), .inc(inc_abort), .clr(stat_clr), .cnt(cnt_abort)
  );
  sat_counter #(.W(CNT_W)) u_cnt_tmo (
    .clk(clk), .rst_n(rst_n), .inc(inc_tmo), .clr(stat_clr), .cnt(cnt_tmo)
  );

  assign dec_en      = dec_en_q;
  assign dec_rst     = dec_rst_q;
  assign st.st_valid = st_valid_q;
  assign st.st_code  = st_code_q;
  assign st.st_ovf   = st_ovf_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_rx_decap_ctrl.sv
// Directed bench for rx_decap_ctrl: status codes go through a scoreboard
// queue; engine controls and counters are checked at fixed cycle points.
module tb_rx_decap_ctrl;
  import rx_ctrl_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk, rst_n;
  logic cfg_enable, gmii_dv, gmii_er;
  logic dec_en, dec_rst, dec_idle, dec_crc_ok, dec_adr_err, dec_len_err;
  logic stat_clr;
  logic [TB_CNT_W-1:0] cnt_ok, cnt_crc, cnt_adr, cnt_abort, cnt_tmo;
  state_t dbg_state;

  rx_decap_ctrl_if ifc ();

  rx_decap_ctrl #(
    .MAX_FRAME_CYCLES(12500), .RST_CYCLES(4), .IFG_CYCLES(12), .CNT_W(TB_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable),
    .gmii_dv(gmii_dv), .gmii_er(gmii_er),
    .dec_en(dec_en), .dec_rst(dec_rst), .dec_idle(dec_idle),
    .dec_crc_ok(dec_crc_ok), .dec_adr_err(dec_adr_err), .dec_len_err(dec_len_err),
    .st(ifc.master), .stat_clr(stat_clr),
    .cnt_ok(cnt_ok), .cnt_crc(cnt_crc), .cnt_adr(cnt_adr),
    .cnt_abort(cnt_abort), .cnt_tmo(cnt_tmo), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted status must match the queue head.
  always @(negedge clk) begin
    if (rst_n && ifc.st_valid && ifc.st_ready) begin
      if (exp_q.size() == 0) begin
        check("st_unexpected", 32'(ifc.st_code), 32'hFFFF_FFFF);
      end else begin
        check("st_code", 32'(ifc.st_code), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string name, input state_t s, input int budget);
    int k;
    k = 0;
    while (dbg_state != s && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(dbg_state), 32'(s));
  endtask

  // Starts in IDLE; frame of len engine-busy cycles, outcome flags applied at
  // the completion cycle. clr_done pulses stat_clr on the DONE edge.
  task automatic run_frame(input int len, input logic crc_ok, input logic adr,
                           input logic len_e, input logic clr_done);
    dec_idle = 1'b0;
    tick(len);
    dec_crc_ok  = crc_ok;
    dec_adr_err = adr;
    dec_len_err = len_e;
    dec_idle    = 1'b1;
    tick(1);
    stat_clr = clr_done;
    tick(1);
    stat_clr    = 1'b0;
    dec_crc_ok  = 1'b1;
    dec_adr_err = 1'b0;
    dec_len_err = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_enable = 1'b0; gmii_dv = 1'b0; gmii_er = 1'b0;
    dec_idle = 1'b1; dec_crc_ok = 1'b1; dec_adr_err = 1'b0; dec_len_err = 1'b0;
    stat_clr = 1'b0; ifc.st_ready = 1'b1;
    tick(2);
    check("rst_dec_en", 32'(dec_en), 0);
    check("rst_dec_rst", 32'(dec_rst), 1);
    check("rst_st_valid", 32'(ifc.st_valid), 0);
    check("rst_st_ovf", 32'(ifc.st_ovf), 0);
    check("rst_cnt_ok", 32'(cnt_ok), 0);
    check("rst_state", 32'(dbg_state), 32'(DISABLED));
    rst_n = 1'b1;

    // Enable with a quiet line: engine engages after 12 idle cycles.
    cfg_enable = 1'b1;
    tick(12);
    check("ifg_dec_en_early", 32'(dec_en), 0);
    check("ifg_dec_rst", 32'(dec_rst), 0);
    tick(1);
    check("ifg_dec_en_on", 32'(dec_en), 1);
    exp_q.push_back(3'd0);
    run_frame(80, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    check("ok_cnt_ok", 32'(cnt_ok), 1);

    // Disable mid-frame: the frame completes, then the controller disables.
    dec_idle = 1'b0;
    tick(3);
    cfg_enable = 1'b0;
    tick(3);
    check("dis_still_recv", 32'(dbg_state), 32'(RECV));
    exp_q.push_back(3'd0);
    dec_idle = 1'b1;
    tick(2);
    check("dis_state", 32'(dbg_state), 32'(DISABLED));
    check("dis_dec_en", 32'(dec_en), 0);
    check("dis_dec_rst", 32'(dec_rst), 1);

    // Enable during a frame; a short gap restarts the idle count.
    gmii_dv = 1'b1;
    cfg_enable = 1'b1;
    tick(5);
    check("dv_hold_state", 32'(dbg_state), 32'(WAIT_IFG));
    gmii_dv = 1'b0;
    tick(5);
    gmii_dv = 1'b1;
    tick(1);
    gmii_dv = 1'b0;
    tick(11);
    check("gap_dec_en_early", 32'(dec_en), 0);
    tick(1);
    check("gap_dec_en_on", 32'(dec_en), 1);

    // Classification: CRC, LEN, and ADDR winning over LEN and CRC.
    exp_q.push_back(3'd1);
    run_frame(10, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(3'd3);
    run_frame(7, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back(3'd2);
    run_frame(4, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    check("cls_cnt_ok", 32'(cnt_ok), 2);
    check("cls_cnt_crc", 32'(cnt_crc), 1);
    check("cls_cnt_adr", 32'(cnt_adr), 1);

    // Abort: GMII error during an active frame.
    dec_idle = 1'b0;
    gmii_dv  = 1'b1;
    tick(5);
    exp_q.push_back(3'd4);
    gmii_er = 1'b1;
    tick(1);
    gmii_er = 1'b0;
    gmii_dv = 1'b0;
    dec_idle = 1'b1;
    check("abort_dec_en", 32'(dec_en), 0);
    check("abort_dec_rst_1", 32'(dec_rst), 1);
    tick(3);
    check("abort_dec_rst_4", 32'(dec_rst), 1);
    tick(1);
    check("abort_dec_rst_off", 32'(dec_rst), 0);
    check("abort_state", 32'(dbg_state), 32'(WAIT_IFG));
    check("abort_cnt", 32'(cnt_abort), 1);
    wait_state("abort_reidle", IDLE, 40);

    // Timeout: engine never returns to idle.
    exp_q.push_back(3'd5);
    dec_idle = 1'b0;
    tick(1);
    tick(12499);
    check("tmo_still_recv", 32'(dbg_state), 32'(RECV));
    tick(1);
    check("tmo_state", 32'(dbg_state), 32'(RECOVER));
    check("tmo_dec_rst", 32'(dec_rst), 1);
    dec_idle = 1'b1;
    tick(2);
    check("tmo_cnt", 32'(cnt_tmo), 1);
    wait_state("tmo_reidle", IDLE, 40);

    // Overflow: host stalls across two frames, second status is dropped.
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    check("clr_cnt_ok", 32'(cnt_ok), 0);
    check("clr_cnt_tmo", 32'(cnt_tmo), 0);
    ifc.st_ready = 1'b0;
    exp_q.push_back(3'd2);
    run_frame(6, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    check("ovf_st_valid", 32'(ifc.st_valid), 1);
    check("ovf_st_code", 32'(ifc.st_code), 2);
    check("ovf_flag", 32'(ifc.st_ovf), 1);
    check("ovf_cnt_adr", 32'(cnt_adr), 1);
    check("ovf_cnt_ok", 32'(cnt_ok), 1);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    check("ovf_clr_cnt_adr", 32'(cnt_adr), 0);
    check("ovf_clr_cnt_ok", 32'(cnt_ok), 0);
    check("ovf_clr_flag", 32'(ifc.st_ovf), 0);
    check("ovf_clr_st_valid", 32'(ifc.st_valid), 1);
    ifc.st_ready = 1'b1;
    tick(2);

    // Saturation, then clear racing an increment.
    for (int i = 0; i < CNT_MAX + 1; i++) begin
      exp_q.push_back(3'd0);
      run_frame(2 + (i % 3), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick(1);
    check("sat_cnt_ok", 32'(cnt_ok), CNT_MAX);
    exp_q.push_back(3'd0);
    run_frame(3, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    check("clr_vs_inc", 32'(cnt_ok), 0);

    tick(5);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
